i2c_write_master: RTL
=====================

# i2c_write_master

Single-byte I2C write master that produces SCL and the SDA output-enable/data pair consumed by the SDA pad stage (`io_block`, which tri-states `sda` when `sda_oe`=0). One transaction is START, address byte {addr,0}, ACK, data byte, ACK, STOP. ACK is sampled from the returned `sda_in`. Sits between the register/command logic and the pad.

## Interface
- `CLK_DIV`, 4, m_clk cycles per SCL quarter-period (≥1)
- `m_clk` in 1, system clock, all logic on rising edge
- `m_rst` in 1, synchronous, active-high reset
- `start` in 1, request pulse; accepted only when `busy`=0
- `addr` in 7, slave address; latched on accept
- `data` in 8, write byte; latched on accept
- `sda_in` in 1, bus SDA level read back from pad
- `scl` out 1, SCL drive level
- `sda_oe` out 1, 1 = drive SDA with `sda_out`; 0 = release
- `sda_out` out 1, SDA drive value when `sda_oe`=1
- `busy` out 1, transaction in progress
- `done` out 1, one-cycle completion pulse
- `ack_err` out 1, slave NACKed (address or data); sticky until next accept

## Operation
- Reset values: `scl`=1, `sda_oe`=0, `sda_out`=1, `busy`=0, `done`=0, `ack_err`=0, FSM=IDLE, counters 0.
- Tick divider counts 0..CLK_DIV-1; quarter ends on its last count. Quarter counter q 0..3; bit counter 7..0, MSB first.
- States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE.
- IDLE: `start`=1 -> latch shift={addr,1'b0} and `data`, clear `ack_err`, `busy`=1, go START.
- START (4 quarters, oe=1): q0,q1 scl=1 sda=1; q2 scl=1 sda=0; q3 scl=0 sda=0 -> ADDR.
- ADDR/DATA per bit (oe=1): q0 scl=0 sda=bit; q1,q2 scl=1 sda=bit; q3 scl=0 sda=bit. After 8 bits -> ACK1/ACK2.
- ACK1/ACK2 (oe=0, sda_out=1): same SCL pattern; sample `sda_in` on last cycle of q2. 0 = ACK -> next (DATA / STOP). 1 = NACK -> `ack_err`=1, go STOP (ACK1 NACK skips DATA).
- STOP (oe=1): q0 scl=0 sda=0; q1 scl=1 sda=0; q2,q3 scl=1 sda=1 -> DONE.
- DONE: one cycle; `done`=1, `busy`=0, `sda_oe`=0, `sda_out`=1, `scl`=1 -> IDLE.
- `start` while `busy`=1 or in DONE: ignored, no effect on latched operands.
- `m_rst` mid-transaction: all outputs to reset values on that edge. Bus released; no STOP is generated.
- Divider width ceil(log2(CLK_DIV)), min 1 bit; no overflow at CLK_DIV=1.

## Timing
- All outputs registered; output levels change on the first cycle of each quarter.
- Accept at edge N -> `busy`=1 and START q0 from cycle N+1.
- Full ACKed transaction: 80 quarters (4+32+4+32+4+4). `done` at cycle N+1+80·CLK_DIV; 321 cycles after accept for CLK_DIV=4.
- Address-NACK transaction: 44 quarters; `done` at N+1+44·CLK_DIV.
- `busy` falls in the `done` cycle. A new `start` is accepted the following cycle at the earliest. `ack_err` holds its value until that accept.
- SDA changes only while scl=0, except START q2 and STOP q2 (falling and rising edges with scl=1).

## Test plan
- Reset: assert `m_rst` 2 cycles -> scl=1, sda_oe=0, sda_out=1, busy=0, done=0, ack_err=0.
- CLK_DIV=4, addr=7'h50, data=8'hA5, `sda_in`=0 in ACKs -> SDA bits 1010_0000 then 1010_0101 sampled at SCL high; done at accept+321; ack_err=0.
- Same request, `sda_in`=1 during ACK1 -> no DATA phase, STOP follows; done at accept+177; ack_err=1.
- ACK1 ok, `sda_in`=1 in ACK2 -> full 321-cycle length; ack_err=1. ack_err clears on the next accepted start.
- `start` pulsed mid-transaction with addr=7'h7F, data=8'h00 -> ignored; bus sequence and latched operands unchanged.
- `m_rst` during DATA bit 3 -> outputs at reset values the next cycle. A `start` after reset runs a full, correct transaction. CLK_DIV=1 run: done at accept+81.

Source files
------------

// File: rtl/i2c_write_master.sv
// i2c_write_master: one-byte I2C write (START, {addr,W}, ACK, data, ACK, STOP).
// Outputs are registered from the next bus position, so levels switch on quarter boundaries.
module i2c_write_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       m_clk,
  input  logic       m_rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic [1:0]    q, q_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_r, data_r_n;
  logic          ack_err_n, scl_n, sda_oe_n, sda_out_n;
  logic          busy_n, done_n, q_end, mid;

  assign q_end = (div == DIV_LAST);

  always_comb begin
    state_n   = state;
    div_n     = div;
    q_n       = q;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_r_n  = data_r;
    ack_err_n = ack_err;
    if (state == IDLE) begin
      div_n = '0;
      q_n   = '0;
      if (start) begin
        state_n   = START;
        shift_n   = {addr, 1'b0};
        data_r_n  = data;
        ack_err_n = 1'b0;
      end
    end else if (state == DONE) begin
      state_n = IDLE;
    end else begin
      div_n = q_end ? '0 : div + 1'b1;
      if (q_end) begin
        q_n = q + 2'd1;
        if ((state == ACK1 || state == ACK2) && q == 2'd2)
          ack_err_n = ack_err | sda_in;
        if (q == 2'd3) begin
          unique case (state)
            START: begin
              state_n   = ADDR;
              bit_cnt_n = 3'd7;
            end
            ADDR, DATA: begin
              if (bit_cnt == 3'd0)
                state_n = (state == ADDR) ? ACK1 : ACK2;
              else
                bit_cnt_n = bit_cnt - 3'd1;
            end
            ACK1: begin
              // an address NACK skips the data byte entirely
              if (ack_err) begin
                state_n = STOP;
              end else begin
                state_n   = DATA;
                bit_cnt_n = 3'd7;
                shift_n   = data_r;
              end
            end
            ACK2:    state_n = STOP;
            STOP:    state_n = DONE;
            default: state_n = state;
          endcase
        end
      end
    end
  end

  assign mid = (q_n == 2'd1) || (q_n == 2'd2);

  always_comb begin
    scl_n     = 1'b1;
    sda_oe_n  = 1'b0;
    sda_out_n = 1'b1;
    unique case (state_n)
      START: begin
        sda_oe_n  = 1'b1;
        scl_n     = (q_n != 2'd3);
        sda_out_n = (q_n < 2'd2);
      end
      ADDR, DATA: begin
        sda_oe_n  = 1'b1;
        scl_n     = mid;
        sda_out_n = shift_n[bit_cnt_n];
      end
      ACK1, ACK2: scl_n = mid;
      STOP: begin
        sda_oe_n  = 1'b1;
        scl_n     = (q_n != 2'd0);
        sda_out_n = q_n[1];
      end
      default: begin
        scl_n     = 1'b1;
        sda_oe_n  = 1'b0;
        sda_out_n = 1'b1;
      end
    endcase
    busy_n = (state_n != IDLE) && (state_n != DONE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      state   <= IDLE;
      div     <= '0;
      q       <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_r  <= '0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      sda_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      q       <= q_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      data_r  <= data_r_n;
      ack_err <= ack_err_n;
      scl     <= scl_n;
      sda_oe  <= sda_oe_n;
      sda_out <= sda_out_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule
